// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush,
// data-memory wait, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [3:0] NO_REG       = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_read,
  input  logic [3:0]  ex_dest_addr,
  input  logic        ex_is_bubble,
  input  logic        ex_branch_taken,
  input  logic [3:0]  id_src_addr,
  input  logic [3:0]  id_dest_addr,
  input  logic        id_use_src,
  input  logic        id_use_dest,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        make_bubble,
  output logic [15:0] stall_count,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10,
    MEM_WAIT   = 2'b11
  } state_t;

  // The branch cycle itself is the first squashed cycle.
  localparam logic [1:0] FC_M1 = 2'(FLUSH_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [1:0] cnt;
  logic [1:0] cnt_nx;
  logic       lu;
  logic       stall_req;
  logic       flush_req;
  logic       bubble_req;

  assign lu = ex_mem_read & ~ex_is_bubble
            & (ex_dest_addr != NO_REG)
            & ((id_use_src  & (id_src_addr  == ex_dest_addr))
             | (id_use_dest & (id_dest_addr == ex_dest_addr)));

  // Next state and raw requests; mem_busy > branch > load-use.
  always_comb begin
    stall_req  = 1'b0;
    flush_req  = 1'b0;
    bubble_req = 1'b0;
    state_nx   = state;
    cnt_nx     = cnt;
    if (state == FLUSH && !mem_busy) begin
      flush_req  = 1'b1;
      bubble_req = 1'b1;
      if (cnt <= 2'd1) begin
        cnt_nx   = 2'd0;
        state_nx = RUN;
      end else begin
        cnt_nx   = cnt - 2'd1;
      end
    end else if (mem_busy) begin
      stall_req  = 1'b1;
      bubble_req = 1'b1;
      cnt_nx     = 2'd0;
      state_nx   = MEM_WAIT;
    end else if (ex_branch_taken) begin
      flush_req  = 1'b1;
      bubble_req = 1'b1;
      cnt_nx     = FC_M1;
      state_nx   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (lu && state != LOAD_STALL) begin
      stall_req  = 1'b1;
      bubble_req = 1'b1;
      cnt_nx     = 2'd0;
      state_nx   = LOAD_STALL;
    end else begin
      cnt_nx     = 2'd0;
      state_nx   = RUN;
    end
  end

  // Reset masks every control output; flush beats stall.
  always_comb begin
    pc_stall    = ~rst & stall_req;
    ifid_flush  = ~rst & flush_req;
    ifid_stall  = ~rst & stall_req & ~flush_req;
    make_bubble = ~rst & bubble_req;
  end

  assign state_o = state;

  // State, flush counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= 2'd0;
      stall_count <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (pc_stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (FLUSH_CYCLES=2).
// Expected results are queued at drive time, popped at sample.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_read;
  logic [3:0]  ex_dest_addr;
  logic        ex_is_bubble;
  logic        ex_branch_taken;
  logic [3:0]  id_src_addr;
  logic [3:0]  id_dest_addr;
  logic        id_use_src;
  logic        id_use_dest;
  logic        mem_busy;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        make_bubble;
  logic [15:0] stall_count;
  logic [1:0]  state_o;

  typedef struct packed {
    logic        ps;
    logic        is;
    logic        fl;
    logic        mb;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = 16'd0;

  hazard_ctrl #(.FLUSH_CYCLES(2), .NO_REG(4'b1111)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_read(ex_mem_read), .ex_dest_addr(ex_dest_addr),
    .ex_is_bubble(ex_is_bubble), .ex_branch_taken(ex_branch_taken),
    .id_src_addr(id_src_addr), .id_dest_addr(id_dest_addr),
    .id_use_src(id_use_src), .id_use_dest(id_use_dest),
    .mem_busy(mem_busy), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .make_bubble(make_bubble), .stall_count(stall_count),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic r, input logic mr,
                     input logic [3:0] ed, input logic eb,
                     input logic br, input logic [3:0] is_,
                     input logic [3:0] id_, input logic us,
                     input logic ud, input logic mbz);
    @(negedge clk);
    rst = r; ex_mem_read = mr; ex_dest_addr = ed;
    ex_is_bubble = eb; ex_branch_taken = br;
    id_src_addr = is_; id_dest_addr = id_;
    id_use_src = us; id_use_dest = ud; mem_busy = mbz;
  endtask

  task automatic adv_cnt(input logic ps);
    if (rst) exp_cnt = 16'd0;
    else if (ps && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic step(input string tag, input logic ps,
                      input logic is, input logic fl,
                      input logic mb, input logic [1:0] st);
    exp_t e;
    exp_t g;
    e = '{ps: ps, is: is, fl: fl, mb: mb, st: st, cnt: exp_cnt};
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk({tag, ".pc_stall"},    16'(pc_stall),    16'(g.ps));
    chk({tag, ".ifid_stall"},  16'(ifid_stall),  16'(g.is));
    chk({tag, ".ifid_flush"},  16'(ifid_flush),  16'(g.fl));
    chk({tag, ".make_bubble"}, 16'(make_bubble), 16'(g.mb));
    chk({tag, ".state"},       16'(state_o),     16'(g.st));
    chk({tag, ".stall_count"}, stall_count,      g.cnt);
    adv_cnt(ps);
  endtask

  initial begin
    // reset with every hazard source active
    set(1, 1, 4'd3, 0, 1, 4'd3, 4'd0, 1, 0, 1);
    adv_cnt(0);
    set(1, 1, 4'd3, 0, 1, 4'd3, 4'd0, 1, 0, 1);
    step("rst", 0, 0, 0, 0, 2'd0);

    // no false hazards
    set(0, 1, 4'hF, 0, 0, 4'hF, 4'd0, 1, 0, 0);
    step("noreg", 0, 0, 0, 0, 2'd0);
    set(0, 1, 4'd3, 1, 0, 4'd3, 4'd0, 1, 0, 0);
    step("bubble", 0, 0, 0, 0, 2'd0);
    set(0, 1, 4'd3, 0, 0, 4'd3, 4'd0, 0, 0, 0);
    step("nouse", 0, 0, 0, 0, 2'd0);

    // load-use on src, held through LOAD_STALL
    set(0, 1, 4'd3, 0, 0, 4'd3, 4'd0, 1, 0, 0);
    step("lu", 1, 1, 0, 1, 2'd0);
    set(0, 1, 4'd3, 0, 0, 4'd3, 4'd0, 1, 0, 0);
    step("lu_hold", 0, 0, 0, 0, 2'd1);
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("lu_done", 0, 0, 0, 0, 2'd0);

    // load-use via dest operand
    set(0, 1, 4'd7, 0, 0, 4'd1, 4'd7, 0, 1, 0);
    step("lu_dst", 1, 1, 0, 1, 2'd0);
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("lu_dst2", 0, 0, 0, 0, 2'd1);

    // branch: two flush cycles, LU ignored in FLUSH
    set(0, 0, 4'd0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
    step("br", 0, 0, 1, 1, 2'd0);
    set(0, 1, 4'd5, 0, 0, 4'd5, 4'd0, 1, 0, 0);
    step("br_fl", 0, 0, 1, 1, 2'd2);
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("br_end", 0, 0, 0, 0, 2'd0);

    // reset then memory wait with LU and branch
    set(1, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("rst2", 0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      set(0, 1, 4'd3, 0, 1, 4'd3, 4'd0, 1, 0, 1);
      step($sformatf("mw%0d", i), 1, 1, 0, 1,
           (i == 0) ? 2'd0 : 2'd3);
    end
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("mw_rel", 0, 0, 0, 0, 2'd3);
    chk("mw_cnt3", 16'(exp_cnt), 16'd3);
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("mw_run", 0, 0, 0, 0, 2'd0);

    // reset in the FLUSH cycle
    set(0, 0, 4'd0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
    step("rf_br", 0, 0, 1, 1, 2'd0);
    set(1, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("rf_rst", 0, 0, 0, 0, 2'd2);
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("rf_after", 0, 0, 0, 0, 2'd0);

    // branch during LOAD_STALL
    set(0, 1, 4'd2, 0, 0, 4'd2, 4'd0, 1, 0, 0);
    step("ls_lu", 1, 1, 0, 1, 2'd0);
    set(0, 0, 4'd0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
    step("ls_br", 0, 0, 1, 1, 2'd1);
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("ls_fl", 0, 0, 1, 1, 2'd2);

    // mem_busy pre-empts FLUSH; branch on release acts as RUN
    set(0, 0, 4'd0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
    step("pf_br", 0, 0, 1, 1, 2'd0);
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 1);
    step("pf_mb", 1, 1, 0, 1, 2'd2);
    set(0, 0, 4'd0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
    step("pf_rel", 0, 0, 1, 1, 2'd3);
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("pf_fl", 0, 0, 1, 1, 2'd2);
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("pf_run", 0, 0, 0, 0, 2'd0);

    // saturation
    set(1, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    adv_cnt(0);
    for (int i = 0; i < 65540; i++) begin
      set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 1);
      adv_cnt(1);
    end
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 1);
    step("sat", 1, 1, 0, 1, 2'd3);
    chk("sat_val", stall_count, 16'hFFFF);
    set(0, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step("sat_rel", 0, 0, 0, 0, 2'd3);

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter FLUSH_CYCLES, default 2, number of cycles fetch/decode are squashed after a taken branch (legal 1..3).
REQ-002 SHALL provide parameter NO_REG, default 4'b1111, register-address code meaning "no register / bubble".
REQ-003 SHALL have clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ex_mem_read  input  1  instruction now in EX (ID/EX output side) reads memory.
REQ-006 SHALL have ex_dest_addr  input  4  EX-stage destination register address.
REQ-007 SHALL have ex_is_bubble  input  1  EX-stage slot holds a bubble.
REQ-008 SHALL have ex_branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-009 SHALL have id_src_addr, id_dest_addr  input  4 each  decode-stage operand addresses.
REQ-010 SHALL have id_use_src, id_use_dest  input  1 each  decode instruction reads that operand.
REQ-011 SHALL have mem_busy  input  1  data memory cannot accept/complete an access this cycle.
REQ-012 SHALL have pc_stall, ifid_stall  output  1 each  hold PC / hold IF-ID register.
REQ-013 SHALL have ifid_flush  output  1  replace IF-ID contents with NOP at next edge.
REQ-014 SHALL have make_bubble  output  1  drives ID/EX makeMeBubble input.
REQ-015 SHALL have stall_count  output  16  saturating count of cycles with pc_stall=1.
REQ-016 SHALL have state_o  output  2  current FSM state encoding.

Function
REQ-017 SHALL implement FSM states RUN=00, LOAD_STALL=01, FLUSH=10, MEM_WAIT=11.
REQ-018 Load-use hazard (LU) SHALL be: ex_mem_read & ~ex_is_bubble & ex_dest_addr!=NO_REG & ((id_use_src & id_src_addr==ex_dest_addr) | (id_use_dest & id_dest_addr==ex_dest_addr)).
REQ-019 Priority within a cycle SHALL be mem_busy > ex_branch_taken > LU.
REQ-020 In RUN with mem_busy=1: pc_stall=ifid_stall=make_bubble=1 same cycle (combinational); next state MEM_WAIT.
REQ-021 MEM_WAIT: pc_stall=ifid_stall=make_bubble=1 while mem_busy=1; first cycle mem_busy=0 outputs SHALL be evaluated as RUN and state returns to RUN.
REQ-022 In RUN with ex_branch_taken=1 (mem_busy=0): ifid_flush=make_bubble=1, pc_stall=0 same cycle; internal flush counter loads FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES>1 else RUN.
REQ-023 FLUSH: ifid_flush=make_bubble=1; counter decrements each cycle; return to RUN after counter reaches 0 (total flush cycles = FLUSH_CYCLES); LU SHALL be ignored in FLUSH.
REQ-024 In RUN with LU=1 (no higher priority event): pc_stall=ifid_stall=make_bubble=1 same cycle; next state LOAD_STALL.
REQ-025 LOAD_STALL: all outputs 0 except state_o; LU re-evaluation suppressed for that one cycle; next state RUN. Load-use penalty SHALL be exactly 1 cycle.
REQ-026 mem_busy=1 in LOAD_STALL or FLUSH SHALL pre-empt: outputs per REQ-020, next state MEM_WAIT, flush counter cleared.
REQ-027 ex_branch_taken=1 in LOAD_STALL SHALL act as in RUN (REQ-022).
REQ-028 ifid_stall and ifid_flush SHALL never both be 1; flush wins if both requested.
REQ-029 stall_count SHALL increment at each edge where pc_stall=1, saturating at 16'hFFFF.

Reset
REQ-030 While rst=1 all outputs except state_o SHALL be 0, regardless of inputs.
REQ-031 At an edge with rst=1: state=RUN, flush counter=0, stall_count=0; reset mid-FLUSH or mid-MEM_WAIT SHALL abort it with no residual stall/flush afterwards.

Verification
REQ-032 Load-use: ex_mem_read=1, ex_dest_addr=3, id_src_addr=3, id_use_src=1 -> make_bubble=pc_stall=1 one cycle, next cycle all 0 in LOAD_STALL, then RUN; stall_count=1.
REQ-033 No false hazard: same as REQ-032 but ex_dest_addr=4'hF or ex_is_bubble=1 or id_use_src=0 -> no stall, stall_count stays 0.
REQ-034 Branch: ex_branch_taken=1 one cycle, FLUSH_CYCLES=2 -> ifid_flush=make_bubble=1 for exactly 2 cycles, pc_stall=0 throughout.
REQ-035 Memory wait: mem_busy=1 for 3 cycles together with LU and branch -> pc_stall=1 for 3 cycles, no flush; branch ignored; stall_count=3.
REQ-036 Reset mid-FLUSH: assert rst in the FLUSH cycle -> outputs 0 that cycle, state RUN next, stall_count=0.
REQ-037 Saturation: force 65536+ stall cycles -> stall_count holds 16'hFFFF.
